// File: rtl/spine_pkg.sv
// Shared definitions for the spine router output-port arbiter: flit type codes,
// arbiter state encoding and the flit type extraction helper.
package spine_pkg;

  localparam int SPINE_DWIDTH = 16;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [1:0] flit_type(input logic [SPINE_DWIDTH-1:0] data);
    return data[SPINE_DWIDTH-1 -: 2];
  endfunction

endpackage

// File: rtl/spine_port_arbiter_rr_pick.sv
// Round-robin pick: first asserted req at or after ptr, wrapping N-1 -> 0.
// Purely combinational; returns one-hot winner, its index and an any-request flag.
module rr_pick #(
  parameter  int N  = 11,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  int p;

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    p   = 0;
    for (int k = 0; k < N; k++) begin
      p = (int'(ptr) + k) % N;
      if (!any && req[p]) begin
        any    = 1'b1;
        win[p] = 1'b1;
        idx    = IW'(p);
      end
    end
  end

endmodule

// File: rtl/spine_port_arbiter.sv
// Per-output-port scheduler: round-robin over input ports, packet locking HEAD..TAIL,
// credit flow control to the downstream FIFO. SPINE_ARB_STATS_EN adds grant_cnt.
module spine_port_arbiter
  import spine_pkg::*;
#(
  parameter  int NUM_PORTS  = 11,
  parameter  int DWIDTH     = SPINE_DWIDTH,
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*DWIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [DWIDTH-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        credit_return,
  output logic [CW-1:0]               credits,
  output logic                        locked,
  output logic                        err_proto,
  output logic                        err_credit
`ifdef SPINE_ARB_STATS_EN
  ,
  output logic [15:0]                 grant_cnt
`endif
);

  localparam int            PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CW-1:0] MAX_CRED = CW'(FIFO_DEPTH);

  arb_state_e          state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       lock_port_q, lock_port_d;
  logic [CW-1:0]       credits_q, credits_d;
  logic [DWIDTH-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                err_proto_q, err_proto_d;
  logic                err_credit_q, err_credit_d;

  logic [NUM_PORTS-1:0] pick_win;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic [NUM_PORTS-1:0] gnt_vec;
  logic [PW-1:0]        gnt_idx;
  logic                 do_grant;
  logic [DWIDTH-1:0]    win_data;
  logic [1:0]           win_type;

  rr_pick #(.N(NUM_PORTS)) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant selection: while locked only lock_port may win, and never without a credit.
  always_comb begin
    gnt_vec  = '0;
    gnt_idx  = pick_idx;
    do_grant = 1'b0;
    if (!reset && credits_q != '0) begin
      if (state_q == ARB_LOCKED) begin
        gnt_idx = lock_port_q;
        if (req[lock_port_q]) begin
          do_grant             = 1'b1;
          gnt_vec[lock_port_q] = 1'b1;
        end
      end else if (pick_any) begin
        do_grant = 1'b1;
        gnt_vec  = pick_win;
      end
    end
    win_data = req_data[int'(gnt_idx)*DWIDTH +: DWIDTH];
    win_type = flit_type(win_data);
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_port_d  = lock_port_q;
    credits_d    = credits_q;
    err_proto_d  = err_proto_q;
    err_credit_d = err_credit_q;
    out_valid_d  = do_grant;
    out_data_d   = do_grant ? win_data : out_data_q;

    if (do_grant) begin
      if (state_q == ARB_IDLE) begin
        rr_ptr_d = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        if (win_type == FLIT_HEAD) begin
          state_d     = ARB_LOCKED;
          lock_port_d = gnt_idx;
        end else if (win_type == FLIT_BODY || win_type == FLIT_TAIL) begin
          err_proto_d = 1'b1;
        end
      end else if (win_type == FLIT_TAIL || win_type == FLIT_SINGLE) begin
        state_d = ARB_IDLE;
      end
    end

    // A return that coincides with a grant cancels out, even at full credit.
    case ({do_grant, credit_return})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == MAX_CRED) err_credit_d = 1'b1;
        else                       credits_d    = credits_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      lock_port_q  <= '0;
      credits_q    <= MAX_CRED;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      err_proto_q  <= 1'b0;
      err_credit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_port_q  <= lock_port_d;
      credits_q    <= credits_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      err_proto_q  <= err_proto_d;
      err_credit_q <= err_credit_d;
    end
  end

`ifdef SPINE_ARB_STATS_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (do_grant && grant_cnt_q != 16'hFFFF) grant_cnt_d = grant_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) grant_cnt_q <= '0;
    else       grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

  assign gnt        = gnt_vec;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign credits    = credits_q;
  assign locked     = (state_q == ARB_LOCKED);
  assign err_proto  = err_proto_q;
  assign err_credit = err_credit_q;

endmodule

// File: tb/tb_spine_port_arbiter.sv
// Scoreboard bench for spine_port_arbiter: per-port flit queues feed the DUT, a
// high-level model predicts grants/credits/flags, a monitor checks written flits in order.
module tb_spine_port_arbiter;
  import spine_pkg::*;

  localparam int N     = 11;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            credit_return = 1'b0;
  logic [CW-1:0]   credits;
  logic            locked, err_proto, err_credit;
`ifdef SPINE_ARB_STATS_EN
  logic [15:0]     grant_cnt;
`endif

  spine_port_arbiter #(.NUM_PORTS(N), .DWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .credit_return (credit_return),
    .credits       (credits),
    .locked        (locked),
    .err_proto     (err_proto),
    .err_credit    (err_credit)
`ifdef SPINE_ARB_STATS_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pq[N][$];

  // Reference model state
  int m_cred, m_lp, m_rr, m_gcnt;
  bit m_locked, m_ep, m_ec;
  int seq_no = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int port);
    seq_no++;
    return {t, 4'(port), 10'(seq_no)};
  endfunction

  task automatic push_pkt(input int port, input int nbody);
    pq[port].push_back(mk(FLIT_HEAD, port));
    for (int b = 0; b < nbody; b++) pq[port].push_back(mk(FLIT_BODY, port));
    pq[port].push_back(mk(FLIT_TAIL, port));
  endtask

  task automatic model_reset();
    m_cred = DEPTH; m_lp = 0; m_rr = 0; m_gcnt = 0;
    m_locked = 0; m_ep = 0; m_ec = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) pq[i].delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; req_data = '0; credit_return = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  // One clock: drive from port queues, compare against the model, advance the model.
  task automatic cycle(input logic [N-1:0] mask, input bit cret, output int dut_g);
    int            g;
    logic [N-1:0]  eg;
    logic [DW-1:0] d;
    logic [1:0]    t;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req[i] = mask[i] && (pq[i].size() > 0);
      req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
    credit_return = cret;
    #1;
    g = -1;
    if (m_cred > 0) begin
      if (m_locked) begin
        if (req[m_lp]) g = m_lp;
      end else begin
        for (int k = 0; k < N; k++) begin
          int p;
          p = (m_rr + k) % N;
          if (g < 0 && req[p]) g = p;
        end
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    dut_g = -1;
    for (int i = 0; i < N; i++) if (gnt[i] && dut_g < 0) dut_g = i;
    chk("gnt", 64'(gnt), 64'(eg));
    chk("credits", 64'(credits), 64'(m_cred));
    chk("locked", 64'(locked), 64'(m_locked));
    chk("err_proto", 64'(err_proto), 64'(m_ep));
    chk("err_credit", 64'(err_credit), 64'(m_ec));
`ifdef SPINE_ARB_STATS_EN
    chk("grant_cnt", 64'(grant_cnt), 64'(m_gcnt));
`endif
    if (g >= 0) begin
      d = pq[g].pop_front();
      t = d[DW-1 -: 2];
      exp_q.push_back(d);
      if (m_gcnt < 16'hFFFF) m_gcnt++;
      if (!m_locked) begin
        m_rr = (g + 1) % N;
        if (t == FLIT_HEAD) begin m_locked = 1; m_lp = g; end
        else if (t == FLIT_BODY || t == FLIT_TAIL) m_ep = 1;
      end else if (t == FLIT_TAIL || t == FLIT_SINGLE) begin
        m_locked = 0;
      end
    end
    if (g >= 0 && !cret) m_cred--;
    else if (g < 0 && cret) begin
      if (m_cred == DEPTH) m_ec = 1;
      else m_cred++;
    end
  endtask

  // Monitor: every write to the downstream FIFO must match the oldest granted flit.
  logic [DW-1:0] mon_e;
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL out_write: got data %0h, expected no write at %0t", out_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(mon_e));
      end
    end else if (exp_q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL out_write: got no write, expected data %0h at %0t", exp_q[0], $time);
    end
  end

  int dg, ng;
  int exp3[6] = '{3, 3, 3, 3, 5, -1};
  logic [N-1:0] rmask;

  initial begin
    model_reset();
    // Reset state
    do_reset();
    cycle('0, 1'b0, dg);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_credits", 64'(credits), 64'(DEPTH));

    // All ports requesting SINGLE, credits returned every cycle: strict rotation
    do_reset();
    for (int i = 0; i < N; i++) begin
      pq[i].push_back(mk(FLIT_SINGLE, i));
      pq[i].push_back(mk(FLIT_SINGLE, i));
    end
    for (int i = 0; i < 12; i++) begin
      cycle('1, 1'b1, dg);
      chk("rotation", 64'(dg), 64'(i % N));
    end

    // Packet lock: port 3 packet completes before port 5 is served
    do_reset();
    push_pkt(3, 2);
    pq[5].push_back(mk(FLIT_SINGLE, 5));
    for (int i = 0; i < 6; i++) begin
      cycle('1, 1'b0, dg);
      chk("lock_seq", 64'(dg), 64'(exp3[i]));
    end

    // Credit exhaustion and single-credit recovery
    do_reset();
    for (int i = 0; i < 10; i++) pq[i].push_back(mk(FLIT_SINGLE, i));
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      cycle('1, 1'b0, dg);
      if (dg >= 0) ng++;
    end
    chk("grants_8", 64'(ng), 64'd8);
    chk("credits_0", 64'(credits), 64'd0);
    cycle('1, 1'b1, dg);
    chk("no_grant_same_cycle", 64'(dg), 64'hFFFF_FFFF_FFFF_FFFF);
    cycle('1, 1'b0, dg);
    chk("grant_after_return", 64'(dg), 64'd8);
    cycle('1, 1'b0, dg);
    chk("starved_again", 64'(dg), 64'hFFFF_FFFF_FFFF_FFFF);

    // Simultaneous grant+return, and over-return at full credit
    do_reset();
    for (int i = 0; i < 5; i++) pq[0].push_back(mk(FLIT_SINGLE, 0));
    for (int i = 0; i < 4; i++) cycle('1, 1'b0, dg);
    cycle('1, 1'b1, dg);
    cycle('0, 1'b0, dg);
    chk("credits_4", 64'(credits), 64'd4);
    for (int i = 0; i < 5; i++) cycle('0, 1'b1, dg);
    cycle('0, 1'b0, dg);
    chk("credits_full", 64'(credits), 64'(DEPTH));
    chk("err_credit_set", 64'(err_credit), 64'd1);

    // Stray BODY while idle; reset while locked
    do_reset();
    pq[2].push_back(mk(FLIT_BODY, 2));
    cycle('1, 1'b0, dg);
    chk("stray_body_grant", 64'(dg), 64'd2);
    cycle('1, 1'b0, dg);
    chk("err_proto_set", 64'(err_proto), 64'd1);
    chk("stray_not_locked", 64'(locked), 64'd0);
    push_pkt(1, 1);
    cycle('1, 1'b0, dg);
    cycle('0, 1'b0, dg);
    chk("locked_mid_pkt", 64'(locked), 64'd1);
    do_reset();
    cycle('0, 1'b0, dg);
    chk("rst_unlock", 64'(locked), 64'd0);
    chk("rst_credits8", 64'(credits), 64'(DEPTH));

    // Randomized traffic: packets, stray BODY flits, request bubbles, random returns
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int port;
        int kind;
        port = $urandom_range(0, N - 1);
        kind = $urandom_range(0, 9);
        if (pq[port].size() < 8) begin
          if (kind < 4)      pq[port].push_back(mk(FLIT_SINGLE, port));
          else if (kind < 9) push_pkt(port, $urandom_range(0, 3));
          else               pq[port].push_back(mk(FLIT_BODY, port));
        end
      end
      for (int i = 0; i < N; i++) rmask[i] = ($urandom_range(0, 3) != 0);
      cycle(rmask, ($urandom_range(0, 1) == 1), dg);
    end
    // Drain with full returns, bounded
    for (int c = 0; c < 400; c++) begin
      ng = 0;
      for (int i = 0; i < N; i++) ng += pq[i].size();
      if (ng == 0) break;
      cycle('1, 1'b1, dg);
    end
    chk("drain_empty", 64'(ng), 64'd0);
    cycle('0, 1'b0, dg);
    cycle('0, 1'b0, dg);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
